// File: rtl/lcd_8080_capture.sv
// lcd_8080_capture
//
// Passive monitor for an 8080-style LCD write bus carrying an ILI9341-style
// command stream. Bus signals are synchronised into the clk domain. A word is
// taken on each rising edge of the write strobe. Column/page window commands
// are decoded and the current pixel coordinate is tracked. Every memory-write
// data word is queued, with its (x, y) position, in a show-ahead FIFO that
// feeds a ready/valid pixel stream.
//
// Ports:
//   clk, reset_n            clock and asynchronous active-low reset
//   lcd_d_c_n               0 = command word, 1 = data word (asynchronous)
//   lcd_wr_n                write strobe, word taken on its rising edge
//   lcd_data[15:0]          bus data
//   pix_valid/pix_ready     pixel stream handshake (FIFO head)
//   pix_x[8:0], pix_y[8:0]  head pixel column / page
//   pix_data[15:0]          head pixel RGB565 word
//   cmd_strobe              one-cycle pulse per received command word
//   cmd_code[7:0]           last command code received
//   overflow                sticky flag, a pixel was dropped on a full FIFO
//   clr_overflow            synchronous clear of overflow (a set wins)

module lcd_8080_capture #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned X_MAX      = 239,
    parameter int unsigned Y_MAX      = 319
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        lcd_d_c_n,
    input  logic        lcd_wr_n,
    input  logic [15:0] lcd_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        cmd_strobe,
    output logic [7:0]  cmd_code,
    output logic        overflow,
    input  logic        clr_overflow
);

    localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [8:0]    EC_RST  = 9'(X_MAX);
    localparam logic [8:0]    EP_RST  = 9'(Y_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_PASET,
        ST_RAMWR,
        ST_OTHER
    } state_t;

    // Bus synchroniser and strobe edge detector
    logic        wr_s1_q, wr_s2_q, wr_s3_q;
    logic        dc_s1_q, dc_s2_q;
    logic [15:0] data_s1_q, data_s2_q;

    // Decoder state, address window and current coordinate
    state_t      state_q;
    logic [1:0]  byte_cnt_q;
    logic        st_hi_q;
    logic [7:0]  st_lo_q;
    logic        end_hi_q;
    logic [8:0]  sc_q, ec_q, sp_q, ep_q;
    logic [8:0]  x_q, y_q;
    logic [8:0]  x_d, y_d;
    logic        cmd_strobe_q;
    logic [7:0]  cmd_code_q;

    // Pixel FIFO
    logic [33:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;

    logic word_ev, cmd_ev, data_ev;
    logic push_req, push_ok, pop;
    logic [8:0] win_start, win_end;

    // The wr_n stages reset high so that leaving reset never looks like a
    // rising strobe edge. Data and d/c are used from stage 2, aligned with
    // the edge detected between stages 2 and 3.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_s1_q   <= 1'b1;
            wr_s2_q   <= 1'b1;
            wr_s3_q   <= 1'b1;
            dc_s1_q   <= 1'b0;
            dc_s2_q   <= 1'b0;
            data_s1_q <= 16'h0000;
            data_s2_q <= 16'h0000;
        end else begin
            wr_s1_q   <= lcd_wr_n;
            wr_s2_q   <= wr_s1_q;
            wr_s3_q   <= wr_s2_q;
            dc_s1_q   <= lcd_d_c_n;
            dc_s2_q   <= dc_s1_q;
            data_s1_q <= lcd_data;
            data_s2_q <= data_s1_q;
        end
    end

    assign word_ev  = wr_s2_q & ~wr_s3_q;
    assign cmd_ev   = word_ev & ~dc_s2_q;
    assign data_ev  = word_ev & dc_s2_q;
    assign push_req = data_ev && (state_q == ST_RAMWR);
    assign pop      = pix_valid && pix_ready;
    // Fullness is judged on the occupancy before any pop in the same cycle.
    assign push_ok  = push_req && (count_q != DEPTH_C);

    // Only the low 9 bits of each 16-bit window bound are kept.
    assign win_start = {st_hi_q, st_lo_q};
    assign win_end   = {end_hi_q, data_s2_q[7:0]};

    // Raster advance: wrap to the window start column at or past the end
    // column, and wrap the page the same way. A start beyond the end makes
    // every step wrap.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (x_q >= ec_q) begin
            x_d = sc_q;
            y_d = (y_q >= ep_q) ? sp_q : (y_q + 9'd1);
        end else begin
            x_d = x_q + 9'd1;
        end
    end

    // Command decoder. Any command word aborts whatever parameter collection
    // or memory write was in progress. Window registers only change when a
    // full four-byte parameter set has arrived.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= 2'd0;
            st_hi_q      <= 1'b0;
            st_lo_q      <= 8'h00;
            end_hi_q     <= 1'b0;
            sc_q         <= 9'd0;
            ec_q         <= EC_RST;
            sp_q         <= 9'd0;
            ep_q         <= EP_RST;
            x_q          <= 9'd0;
            y_q          <= 9'd0;
            cmd_strobe_q <= 1'b0;
            cmd_code_q   <= 8'h00;
        end else begin
            cmd_strobe_q <= 1'b0;
            if (cmd_ev) begin
                cmd_strobe_q <= 1'b1;
                cmd_code_q   <= data_s2_q[7:0];
                byte_cnt_q   <= 2'd0;
                case (data_s2_q[7:0])
                    8'h2A: state_q <= ST_CASET;
                    8'h2B: state_q <= ST_PASET;
                    8'h2C: begin
                        state_q <= ST_RAMWR;
                        x_q     <= sc_q;
                        y_q     <= sp_q;
                    end
                    default: state_q <= ST_OTHER;
                endcase
            end else if (data_ev) begin
                case (state_q)
                    ST_CASET, ST_PASET: begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: st_hi_q  <= data_s2_q[0];
                            2'd1: st_lo_q  <= data_s2_q[7:0];
                            2'd2: end_hi_q <= data_s2_q[0];
                            default: begin
                                if (state_q == ST_CASET) begin
                                    sc_q <= win_start;
                                    ec_q <= win_end;
                                end else begin
                                    sp_q <= win_start;
                                    ep_q <= win_end;
                                end
                                state_q <= ST_IDLE;
                            end
                        endcase
                    end
                    ST_RAMWR: begin
                        // Coordinates advance even when the FIFO drops the word.
                        x_q <= x_d;
                        y_q <= y_d;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Show-ahead pixel FIFO with a sticky overflow flag. The storage is reset
    // so that the head outputs read zero after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 34'd0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {x_q, y_q, data_s2_q};
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (push_req && !push_ok) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign pix_valid  = (count_q != '0);
    assign pix_x      = mem_q[rd_ptr_q][33:25];
    assign pix_y      = mem_q[rd_ptr_q][24:16];
    assign pix_data   = mem_q[rd_ptr_q][15:0];
    assign cmd_strobe = cmd_strobe_q;
    assign cmd_code   = cmd_code_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_lcd_8080_capture.sv
// tb_lcd_8080_capture
//
// Directed bench for lcd_8080_capture. Bus words are driven with slow
// 8080 timing. Popped pixels and command strobes are recorded by monitors
// sampling on the falling clock edge. Each recorded value is compared against
// a hand-computed expectation.

module tb_lcd_8080_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        lcd_d_c_n;
    logic        lcd_wr_n;
    logic [15:0] lcd_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [8:0]  pix_x;
    logic [8:0]  pix_y;
    logic [15:0] pix_data;
    logic        cmd_strobe;
    logic [7:0]  cmd_code;
    logic        overflow;
    logic        clr_overflow;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [33:0] capQ[$];
    logic [7:0]  strobeQ[$];

    always #5 clk = ~clk;

    lcd_8080_capture #(
        .FIFO_DEPTH(16),
        .X_MAX(239),
        .Y_MAX(319)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .lcd_d_c_n(lcd_d_c_n),
        .lcd_wr_n(lcd_wr_n),
        .lcd_data(lcd_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .pix_data(pix_data),
        .cmd_strobe(cmd_strobe),
        .cmd_code(cmd_code),
        .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    // pix_ready only changes just after a rising edge, so what is seen here
    // is exactly what the next rising edge pops.
    always @(negedge clk) begin
        if (pix_valid && pix_ready) capQ.push_back({pix_x, pix_y, pix_data});
        if (cmd_strobe) strobeQ.push_back(cmd_code);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One bus word: d/c and data set with the strobe low, held 3 clocks
    // before the rising edge and 3 clocks after it.
    task automatic applyStimulus(input logic dc, input logic [15:0] d);
        @(negedge clk);
        lcd_d_c_n = dc;
        lcd_data  = d;
        lcd_wr_n  = 1'b0;
        repeat (3) @(negedge clk);
        lcd_wr_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic setReady(input logic v);
        @(posedge clk);
        #1 pix_ready = v;
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic checkPixel(input string tag, input logic [8:0] ex, input logic [8:0] ey,
                              input logic [15:0] ed);
        logic [33:0] v;
        v = '1;
        if (capQ.size() > 0) v = capQ.pop_front();
        checkOutput({tag, "_xy"}, {14'd0, v[33:16]}, {14'd0, ex, ey});
        checkOutput({tag, "_data"}, {16'd0, v[15:0]}, {16'd0, ed});
    endtask

    task automatic checkResetOutputs(input string p);
        checkOutput({p, "_valid"}, {31'd0, pix_valid}, 32'd0);
        checkOutput({p, "_x"}, {23'd0, pix_x}, 32'd0);
        checkOutput({p, "_y"}, {23'd0, pix_y}, 32'd0);
        checkOutput({p, "_data"}, {16'd0, pix_data}, 32'd0);
        checkOutput({p, "_strobe"}, {31'd0, cmd_strobe}, 32'd0);
        checkOutput({p, "_code"}, {24'd0, cmd_code}, 32'd0);
        checkOutput({p, "_ovf"}, {31'd0, overflow}, 32'd0);
    endtask

    // Expected coordinate of the i-th pixel in the window x 10..12, y 5..6
    function automatic logic [8:0] bpX(input int i);
        return 9'(10 + (i % 3));
    endfunction

    function automatic logic [8:0] bpY(input int i);
        return 9'(5 + ((i / 3) % 2));
    endfunction

    initial begin
        reset_n      = 1'b0;
        lcd_d_c_n    = 1'b1;
        lcd_wr_n     = 1'b1;
        lcd_data     = 16'h0000;
        pix_ready    = 1'b0;
        clr_overflow = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("rst");
        reset_n = 1'b1;
        setReady(1'b1);

        // Window 10..12 x 5..6 and raster order
        capQ.delete();
        strobeQ.delete();
        applyStimulus(1'b0, 16'h002A);
        applyStimulus(1'b1, 16'h0000);
        applyStimulus(1'b1, 16'h000A);
        applyStimulus(1'b1, 16'h0000);
        applyStimulus(1'b1, 16'h000C);
        applyStimulus(1'b0, 16'h002B);
        applyStimulus(1'b1, 16'h0000);
        applyStimulus(1'b1, 16'h0005);
        applyStimulus(1'b1, 16'h0000);
        applyStimulus(1'b1, 16'h0006);
        applyStimulus(1'b0, 16'h002C);
        for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 16'(i));
        repeat (3) @(negedge clk);
        checkOutput("win_count", capQ.size(), 32'd6);
        checkPixel("win_p1", 9'd10, 9'd5, 16'h0001);
        checkPixel("win_p2", 9'd11, 9'd5, 16'h0002);
        checkPixel("win_p3", 9'd12, 9'd5, 16'h0003);
        checkPixel("win_p4", 9'd10, 9'd6, 16'h0004);
        checkPixel("win_p5", 9'd11, 9'd6, 16'h0005);
        checkPixel("win_p6", 9'd12, 9'd6, 16'h0006);
        applyStimulus(1'b1, 16'h0007);
        repeat (2) @(negedge clk);
        checkPixel("win_p7", 9'd10, 9'd5, 16'h0007);
        checkOutput("strb_count", strobeQ.size(), 32'd3);
        checkOutput("strb_2a", {24'd0, (strobeQ.size() > 0) ? strobeQ[0] : 8'hFF}, 32'h2A);
        checkOutput("strb_2b", {24'd0, (strobeQ.size() > 1) ? strobeQ[1] : 8'hFF}, 32'h2B);
        checkOutput("strb_2c", {24'd0, (strobeQ.size() > 2) ? strobeQ[2] : 8'hFF}, 32'h2C);

        // Latency of a data word: valid rises in the cycle after E2
        capQ.delete();
        @(negedge clk);
        lcd_d_c_n = 1'b1;
        lcd_data  = 16'h0055;
        lcd_wr_n  = 1'b0;
        repeat (3) @(negedge clk);
        lcd_wr_n = 1'b1;
        @(negedge clk);
        checkOutput("lat_e0", {31'd0, pix_valid}, 32'd0);
        @(negedge clk);
        checkOutput("lat_e1", {31'd0, pix_valid}, 32'd0);
        @(negedge clk);
        checkOutput("lat_e2", {31'd0, pix_valid}, 32'd1);
        repeat (2) @(negedge clk);
        checkPixel("lat_pix", 9'd11, 9'd5, 16'h0055);

        // Command strobe timing and width
        @(negedge clk);
        lcd_d_c_n = 1'b0;
        lcd_data  = 16'h002C;
        lcd_wr_n  = 1'b0;
        repeat (3) @(negedge clk);
        lcd_wr_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("strb_e1", {31'd0, cmd_strobe}, 32'd0);
        @(negedge clk);
        checkOutput("strb_e2", {31'd0, cmd_strobe}, 32'd1);
        checkOutput("strb_code", {24'd0, cmd_code}, 32'h2C);
        @(negedge clk);
        checkOutput("strb_width", {31'd0, cmd_strobe}, 32'd0);
        repeat (2) @(negedge clk);

        // Backpressure: 20 pixels into a 16-deep FIFO
        setReady(1'b0);
        capQ.delete();
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 16'(16'h0100 + i));
        checkOutput("bp_ovf", {31'd0, overflow}, 32'd1);
        checkOutput("bp_valid", {31'd0, pix_valid}, 32'd1);
        checkOutput("bp_head", {14'd0, pix_x, pix_y}, {14'd0, 9'd10, 9'd5});
        setReady(1'b1);
        repeat (24) @(negedge clk);
        checkOutput("bp_count", capQ.size(), 32'd16);
        for (int i = 0; i < 16; i++) begin
            checkPixel($sformatf("bp_p%0d", i), bpX(i), bpY(i), 16'(16'h0100 + i));
        end
        checkOutput("bp_ovf_sticky", {31'd0, overflow}, 32'd1);
        applyStimulus(1'b1, 16'h0200);
        repeat (2) @(negedge clk);
        checkPixel("bp_cont", bpX(20), bpY(20), 16'h0200);
        @(posedge clk);
        #1 clr_overflow = 1'b1;
        @(posedge clk);
        #1 clr_overflow = 1'b0;
        @(negedge clk);
        checkOutput("bp_ovf_clr", {31'd0, overflow}, 32'd0);

        // Other command with a data parameter: no pixel, window kept
        capQ.delete();
        applyStimulus(1'b0, 16'h0036);
        applyStimulus(1'b1, 16'h0048);
        repeat (3) @(negedge clk);
        checkOutput("oth_code", {24'd0, cmd_code}, 32'h36);
        checkOutput("oth_nopix", capQ.size(), 32'd0);
        applyStimulus(1'b0, 16'h002C);
        applyStimulus(1'b1, 16'h0077);
        repeat (2) @(negedge clk);
        checkPixel("oth_win", 9'd10, 9'd5, 16'h0077);

        // Data in IDLE after reset, then an incomplete CASET
        pulseReset();
        capQ.delete();
        applyStimulus(1'b1, 16'h1234);
        repeat (3) @(negedge clk);
        checkOutput("idle_nopix", capQ.size(), 32'd0);
        applyStimulus(1'b0, 16'h002A);
        applyStimulus(1'b1, 16'h0000);
        applyStimulus(1'b1, 16'h0014);
        applyStimulus(1'b0, 16'h002C);
        applyStimulus(1'b1, 16'hAAAA);
        applyStimulus(1'b1, 16'hBBBB);
        repeat (2) @(negedge clk);
        checkPixel("part_p0", 9'd0, 9'd0, 16'hAAAA);
        checkPixel("part_p1", 9'd1, 9'd0, 16'hBBBB);

        // Reset with five entries queued mid-RAMWR
        setReady(1'b0);
        capQ.delete();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'(16'h0300 + i));
        checkOutput("mid_valid", {31'd0, pix_valid}, 32'd1);
        checkOutput("mid_head", {14'd0, pix_x, pix_y}, {14'd0, 9'd2, 9'd0});
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        checkResetOutputs("mid_rst");
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checkResetOutputs("mid_post");
        setReady(1'b1);
        applyStimulus(1'b1, 16'h5555);
        repeat (3) @(negedge clk);
        checkOutput("mid_nopix", capQ.size(), 32'd0);

        // Default window after reset: 240 columns per page
        applyStimulus(1'b0, 16'h002C);
        for (int i = 0; i < 241; i++) applyStimulus(1'b1, 16'(i));
        repeat (3) @(negedge clk);
        checkOutput("def_count", capQ.size(), 32'd241);
        if (capQ.size() == 241) begin
            checkOutput("def_p0", {14'd0, capQ[0][33:16]}, {14'd0, 9'd0, 9'd0});
            checkOutput("def_p239", {14'd0, capQ[239][33:16]}, {14'd0, 9'd239, 9'd0});
            checkOutput("def_p240", {14'd0, capQ[240][33:16]}, {14'd0, 9'd0, 9'd1});
            checkOutput("def_d240", {16'd0, capQ[240][15:0]}, 32'd240);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
